slant_transmitter: RTL and testbench
====================================

SLANT_TRANSMITTER -- requirements
Module: slant_transmitter

Interface
REQ-001 SHALL have parameter BIT_TIME, default 25: clocks per transmitted symbol, legal range 8..255.
REQ-002 SHALL have parameter PIX_PER_LINE, default 160: Y/C input beats per line.
REQ-003 SHALL have parameter LINES, default 240: lines per frame.
REQ-004 SHALL have parameter GUARD, default 16: zero-sync guard symbols before each HSYNC.
REQ-005 SHALL have ports, in this order:
- clk  in  1  symbol/pixel clock.
- rstn  in  1  reset, asynchronous, active-low.
- tx_en  in  1  level; start or continue frames.
- pix_valid  in  1  pixel beat available.
- pix_y  in  5  luma sample.
- pix_c  in  5  chroma sample.
- pix_ready  out  1  one-cycle accept strobe.
- tx_data  out  6  link symbol; bit5 = serial sync bit, bits[4:0] = payload.
- frame_odd  out  1  parity of the frame being sent.
- tx_busy  out  1  FSM not IDLE.
- underrun  out  1  one-cycle pulse on a missed pixel beat.

Function
REQ-006 SHALL hold each tx_data symbol exactly BIT_TIME clocks. An 8-bit symbol counter runs 0..BIT_TIME-1. The symbol boundary (sym_end) SHALL occur when the counter = BIT_TIME-1; the counter wraps to 0 there.
REQ-007 SHALL implement FSM states IDLE, FHDR, GUARD, HSYNC, PIXEL.
REQ-008 IDLE: counter held at 0, tx_data=6'h00. On tx_en=1, SHALL enter FHDR on the next clock.
REQ-009 FHDR SHALL send 24 symbols. Bit5 = header pattern MSB first: 24'haab155 when frame_odd=0, 24'haa8d55 when frame_odd=1. Bits[4:0]=0.
REQ-010 After FHDR, and after every completed line except the last, SHALL enter GUARD and send GUARD symbols of 6'h00.
REQ-011 HSYNC SHALL send 8 symbols whose bit5 = 8'h55 MSB first, with bits[4:0]=0.
REQ-012 PIXEL SHALL send 2*PIX_PER_LINE symbols, alternating {1'b0,Y} then {1'b0,C}, starting with Y.
REQ-013 pix_ready SHALL pulse for one clock on the first clock of each Y symbol.
- If pix_valid=1 in that clock: pix_y is driven and pix_c is latched for the following C symbol.
- If pix_valid=0: the previous Y/C values are repeated, underrun pulses in that clock, and pixel/line counters still advance.
REQ-014 Bit5 SHALL be 0 for every GUARD and PIXEL symbol.
REQ-015 Counters: pixel counter 0..PIX_PER_LINE-1; line counter 0..LINES-1. Both SHALL wrap to 0 at end of frame.
REQ-016 At the end of the last PIXEL symbol of line LINES-1, frame_odd SHALL toggle.
- Next state is FHDR if tx_en=1, otherwise IDLE.
- tx_en deassertion mid-frame SHALL NOT truncate the frame.
REQ-017 tx_data SHALL change only on the clock after sym_end. It is registered with zero combinational output path.
REQ-018 tx_busy SHALL be 1 in all states except IDLE.
REQ-019 Each symbol transition SHALL occur on the clock after sym_end; no cycle gaps between states.

Reset
REQ-020 When rstn=0, the following SHALL take effect asynchronously:
- state=IDLE; all counters=0.
- tx_data=6'h00, pix_ready=0, underrun=0, tx_busy=0, frame_odd=0.
- latched Y/C=0.
REQ-021 Reset mid-frame SHALL abort immediately. After release, transmission SHALL restart from FHDR with frame_odd=0 if tx_en=1.

Verification
REQ-022 tx_en=1 from reset, BIT_TIME=25 -> first 24 symbols of 25 clocks each carry bit5 sequence 1010_1010_1011_0001_0101_0101 (aab155); the next 16 symbols are 6'h00; then bit5 = 01010101.
REQ-023 pix_valid=1, pix_y=5'h1b, pix_c=5'h04 constant -> PIXEL symbols alternate 6'h1b, 6'h04, one pix_ready pulse per 50 clocks, 160 pulses per line.
REQ-024 LINES=2, PIX_PER_LINE=4, tx_en held -> second frame header = aa8d55, frame_odd=1; third header returns to aab155.
REQ-025 pix_valid=0 for one Y slot after Y=5'h0a, C=5'h11 -> that pair is repeated as 6'h0a, 6'h11; underrun pulses exactly once; the line still ends after the programmed symbol count.
REQ-026 tx_en dropped during line 3 -> frame completes all LINES, then IDLE with tx_data=6'h00 and tx_busy=0.
REQ-027 rstn pulsed low during PIXEL -> outputs reach reset values within the same cycle; restart emits aab155.

Source files
------------

// File: rtl/slant_transmitter.sv
// Slant line transmitter.
// Sends a framed symbol stream on tx_data. Each frame is a 24-symbol header,
// then for every line: a zero guard, an 8-symbol HSYNC and Y/C pixel pairs.
// Each symbol is held for BIT_TIME clocks.
// The FSM state and counters advance at the symbol boundary. tx_data is a pure
// register loaded during the first clock of each symbol, so every symbol
// appears on tx_data one clock after the FSM enters it.
// pix_ready is high in that same first clock. The pixel sampled in that clock
// goes straight into the tx_data register, and no input reaches tx_data
// combinationally.
module slant_transmitter #(
  parameter int BIT_TIME     = 25,
  parameter int PIX_PER_LINE = 160,
  parameter int LINES        = 240,
  parameter int GUARD        = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_en,
  input  logic       pix_valid,
  input  logic [4:0] pix_y,
  input  logic [4:0] pix_c,
  output logic       pix_ready,
  output logic [5:0] tx_data,
  output logic       frame_odd,
  output logic       tx_busy,
  output logic       underrun
);

  localparam logic [7:0]  SYM_LAST   = 8'(BIT_TIME - 1);
  localparam logic [15:0] HDR_LAST   = 16'd23;
  localparam logic [15:0] GUARD_LAST = 16'(GUARD - 1);
  localparam logic [15:0] HS_LAST    = 16'd7;
  localparam logic [15:0] PSYM_LAST  = 16'(2 * PIX_PER_LINE - 1);
  localparam logic [15:0] PIX_LAST   = 16'(PIX_PER_LINE - 1);
  localparam logic [15:0] LINE_LAST  = 16'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FHDR,
    S_GUARD,
    S_HSYNC,
    S_PIXEL
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;        // clock within the current symbol
  logic [15:0] idx_q;        // symbol index within the current state
  logic [15:0] pix_q;        // pixel within the line
  logic [15:0] line_q;       // line within the frame
  logic        frame_odd_q;
  logic        pix_ready_q;
  logic [5:0]  tx_data_q;
  logic [4:0]  y_q;
  logic [4:0]  c_q;

  logic        sym_end;
  logic        sym_first;
  logic [23:0] hdr_sh;
  logic [7:0]  hs_sh;
  logic [5:0]  tx_data_d;

  assign sym_end   = (cnt_q == SYM_LAST);
  assign sym_first = (state_q != S_IDLE) && (cnt_q == 8'd0);
  assign hdr_sh    = (frame_odd_q ? 24'haa8d55 : 24'haab155) << idx_q[4:0];
  assign hs_sh     = 8'h55 << idx_q[2:0];

  // Symbol content for the symbol the FSM is currently in.
  always_comb begin
    tx_data_d = 6'h00;
    case (state_q)
      S_FHDR:  tx_data_d = {hdr_sh[23], 5'b0};
      S_HSYNC: tx_data_d = {hs_sh[7], 5'b0};
      S_PIXEL: begin
        if (idx_q[0]) tx_data_d = {1'b0, c_q};
        else          tx_data_d = {1'b0, (pix_valid ? pix_y : y_q)};
      end
      default: tx_data_d = 6'h00;
    endcase
  end

  // Frame FSM with symbol, pixel and line counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= 16'd0;
      pix_q       <= 16'd0;
      line_q      <= 16'd0;
      frame_odd_q <= 1'b0;
      pix_ready_q <= 1'b0;
      tx_data_q   <= 6'h00;
      y_q         <= 5'd0;
      c_q         <= 5'd0;
    end else begin
      pix_ready_q <= 1'b0;
      if (sym_first) tx_data_q <= tx_data_d;
      // A missed beat keeps the previous pair so it is repeated.
      if (state_q == S_PIXEL && pix_ready_q && pix_valid) begin
        y_q <= pix_y;
        c_q <= pix_c;
      end
      case (state_q)
        S_IDLE: begin
          tx_data_q <= 6'h00;
          cnt_q     <= 8'd0;
          idx_q     <= 16'd0;
          if (tx_en) state_q <= S_FHDR;
        end
        default: begin
          cnt_q <= sym_end ? 8'd0 : cnt_q + 8'd1;
          if (sym_end) begin
            idx_q <= idx_q + 16'd1;
            case (state_q)
              S_FHDR: begin
                if (idx_q == HDR_LAST) begin
                  state_q <= S_GUARD;
                  idx_q   <= 16'd0;
                end
              end
              S_GUARD: begin
                if (idx_q == GUARD_LAST) begin
                  state_q <= S_HSYNC;
                  idx_q   <= 16'd0;
                end
              end
              S_HSYNC: begin
                if (idx_q == HS_LAST) begin
                  state_q     <= S_PIXEL;
                  idx_q       <= 16'd0;
                  pix_ready_q <= 1'b1;
                end
              end
              S_PIXEL: begin
                if (idx_q[0]) pix_q <= (pix_q == PIX_LAST) ? 16'd0 : pix_q + 16'd1;
                if (idx_q == PSYM_LAST) begin
                  idx_q <= 16'd0;
                  if (line_q == LINE_LAST) begin
                    // End of frame: a dropped tx_en only takes effect here.
                    line_q      <= 16'd0;
                    frame_odd_q <= ~frame_odd_q;
                    state_q     <= tx_en ? S_FHDR : S_IDLE;
                  end else begin
                    line_q  <= line_q + 16'd1;
                    state_q <= S_GUARD;
                  end
                end else if (idx_q[0]) begin
                  pix_ready_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign pix_ready = pix_ready_q;
  assign tx_data   = tx_data_q;
  assign frame_odd = frame_odd_q;
  assign tx_busy   = (state_q != S_IDLE);
  assign underrun  = pix_ready_q & ~pix_valid;

endmodule

// File: tb/tb_slant_transmitter.sv
// Bench for slant_transmitter with a small frame geometry.
// The pixel driver answers each pix_ready from a vector table and pushes the
// two expected pixel symbols into exp_q. The symbol monitor rebuilds the
// header/guard/HSYNC structure of each frame. It pops pixel symbols from
// exp_q and checks that every symbol is stable for BIT_TIME clocks.
module tb_slant_transmitter;
  localparam int BT  = 8;
  localparam int PPL = 4;
  localparam int LN  = 4;
  localparam int GD  = 4;
  localparam int BLK = GD + 8 + 2 * PPL;
  localparam int F   = 24 + LN * BLK;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_en = 1'b0;
  logic       pix_valid = 1'b0;
  logic [4:0] pix_y = 5'd0;
  logic [4:0] pix_c = 5'd0;
  logic       pix_ready;
  logic [5:0] tx_data;
  logic       frame_odd;
  logic       tx_busy;
  logic       underrun;

  slant_transmitter #(
    .BIT_TIME(BT), .PIX_PER_LINE(PPL), .LINES(LN), .GUARD(GD)
  ) dut (
    .clk(clk), .rstn(rstn), .tx_en(tx_en), .pix_valid(pix_valid),
    .pix_y(pix_y), .pix_c(pix_c), .pix_ready(pix_ready), .tx_data(tx_data),
    .frame_odd(frame_odd), .tx_busy(tx_busy), .underrun(underrun)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] y;
    logic [4:0] c;
    logic [4:0] ey;
    logic [4:0] ec;
    logic       eu;
  } vec_t;

  vec_t       tbl [8];
  logic [5:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_active = 1'b0;
  int         mon_n = 0;
  logic [5:0] first_v = 6'h00;
  int         frame_ctr = 0;
  int         bi = 0;
  int         beats = 0;
  int         und_seen = 0;
  int         und_exp = 0;
  bit         beat_now = 1'b0;
  logic       exp_u = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] frame_sym(input int p, input bit odd, output bit is_pix);
    logic [23:0] hdr;
    logic [7:0]  hs;
    int          q;
    hdr    = odd ? 24'haa8d55 : 24'haab155;
    hs     = 8'h55;
    is_pix = 1'b0;
    if (p < 24) return {hdr[23 - p], 5'b0};
    q = (p - 24) % BLK;
    if (q < GD) return 6'h00;
    if (q < GD + 8) return {hs[7 - (q - GD)], 5'b0};
    is_pix = 1'b1;
    return 6'h00;
  endfunction

  // Symbol monitor: one call per clock, on the falling edge.
  task automatic monitor();
    int         pc;
    int         ph;
    int         fp;
    bit         isp;
    logic [5:0] e;
    if (!mon_active) begin
      if (tx_busy === 1'b1) begin
        mon_active = 1'b1;
        mon_n      = 0;
      end
    end else begin
      mon_n++;
      pc = mon_n - 1;
      ph = pc % BT;
      fp = (pc / BT) % F;
      if (ph == 0) first_v = tx_data;
      if (ph == BT - 1) begin
        e = frame_sym(fp, frame_ctr[0], isp);
        if (isp) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pix_sym f%0d p%0d: got %0h want <none queued>", frame_ctr, fp, tx_data);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("pix_sym f%0d p%0d", frame_ctr, fp), 32'({first_v, tx_data}), 32'({e, e}));
          end
        end else begin
          chk($sformatf("sym f%0d p%0d", frame_ctr, fp), 32'({first_v, tx_data}), 32'({e, e}));
        end
        if (fp == 0) chk($sformatf("frame_odd f%0d", frame_ctr), 32'(frame_odd), 32'(frame_ctr % 2));
        if (fp == F - 1) begin
          frame_ctr++;
          if (tx_busy !== 1'b1) mon_active = 1'b0;
        end
      end
    end
  endtask

  // Driver plus monitor, one clock per call.
  task automatic tick();
    @(negedge clk);
    beat_now = 1'b0;
    if (pix_ready === 1'b1) begin
      pix_valid = tbl[bi].v;
      pix_y     = tbl[bi].y;
      pix_c     = tbl[bi].c;
      exp_q.push_back({1'b0, tbl[bi].ey});
      exp_q.push_back({1'b0, tbl[bi].ec});
      exp_u = tbl[bi].eu;
      if (tbl[bi].eu) und_exp++;
      bi       = (bi + 1) % 8;
      beats++;
      beat_now = 1'b1;
    end else begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_y     = 5'($urandom_range(0, 31));
      pix_c     = 5'($urandom_range(0, 31));
    end
    #1;
    if (underrun === 1'b1) und_seen++;
    if (beat_now) chk("underrun_beat", 32'(underrun), 32'(exp_u));
    monitor();
  endtask

  initial begin
    int k;
    tbl[0] = '{1'b1, 5'h1b, 5'h04, 5'h1b, 5'h04, 1'b0};
    tbl[1] = '{1'b1, 5'h1b, 5'h04, 5'h1b, 5'h04, 1'b0};
    tbl[2] = '{1'b1, 5'h0a, 5'h11, 5'h0a, 5'h11, 1'b0};
    tbl[3] = '{1'b0, 5'h15, 5'h0e, 5'h0a, 5'h11, 1'b1};
    tbl[4] = '{1'b1, 5'h1f, 5'h00, 5'h1f, 5'h00, 1'b0};
    tbl[5] = '{1'b1, 5'h00, 5'h1f, 5'h00, 5'h1f, 1'b0};
    tbl[6] = '{1'b1, 5'h0a, 5'h11, 5'h0a, 5'h11, 1'b0};
    tbl[7] = '{1'b0, 5'h07, 5'h19, 5'h0a, 5'h11, 1'b1};

    repeat (3) tick();
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_pix_ready", 32'(pix_ready), 32'h0);
    chk("rst_tx_busy", 32'(tx_busy), 32'h0);
    chk("rst_frame_odd", 32'(frame_odd), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    rstn  = 1'b1;
    tx_en = 1'b1;

    // Frames 0 and 1 back to back, then drop tx_en early in line 2 of frame 2.
    k = 0;
    while (beats < 2 * LN * PPL + 2 * PPL + 1 && k < 5000) begin tick(); k++; end
    chk("reach_frame2_line2", 32'(beats >= 2 * LN * PPL + 2 * PPL + 1), 32'h1);
    tx_en = 1'b0;
    k = 0;
    while (!(frame_ctr == 3 && !mon_active) && k < 5000) begin tick(); k++; end
    chk("frames_sent", 32'(frame_ctr), 32'd3);
    chk("stopped_at_frame_end", 32'(mon_active), 32'h0);
    chk("rdy_pulses", 32'(beats), 32'(3 * LN * PPL));
    chk("underrun_count", 32'(und_seen), 32'(und_exp));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    repeat (5) tick();
    chk("idle_tx_data", 32'(tx_data), 32'h0);
    chk("idle_tx_busy", 32'(tx_busy), 32'h0);
    chk("idle_frame_odd", 32'(frame_odd), 32'h1);

    // Restart (odd header), then reset in the middle of PIXEL.
    tx_en = 1'b1;
    k = 0;
    while (beats < 3 * LN * PPL + 3 && k < 3000) begin tick(); k++; end
    chk("reach_restart_pixel", 32'(beats >= 3 * LN * PPL + 3), 32'h1);
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    chk("async_tx_data", 32'(tx_data), 32'h0);
    chk("async_pix_ready", 32'(pix_ready), 32'h0);
    chk("async_tx_busy", 32'(tx_busy), 32'h0);
    chk("async_frame_odd", 32'(frame_odd), 32'h0);
    chk("async_underrun", 32'(underrun), 32'h0);
    mon_active = 1'b0;
    exp_q.delete();
    frame_ctr = 0;
    bi = 0;
    tick();
    rstn = 1'b1;

    // One frame after reset: even header again, then idle.
    repeat (BT * 30) tick();
    tx_en = 1'b0;
    k = 0;
    while (!(frame_ctr == 1 && !mon_active) && k < 3000) begin tick(); k++; end
    chk("frames_after_reset", 32'(frame_ctr), 32'd1);
    chk("stopped_after_reset", 32'(mon_active), 32'h0);
    chk("underrun_count_end", 32'(und_seen), 32'(und_exp));
    chk("scoreboard_empty_end", 32'(exp_q.size()), 32'h0);
    repeat (3) tick();
    chk("end_tx_busy", 32'(tx_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
